shake_input_frontend: RTL



---
 rtl/shake_input_frontend_pkg.sv | 24 ++
 rtl/shake_input_frontend_btn_debounce.sv | 47 ++++
 rtl/shake_input_frontend.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/shake_input_frontend_pkg.sv
// Shared types, default constants and width helper for the shake/button input frontend.
package shake_input_frontend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WAIT_LO,
        HOLDOFF
    } shake_state_t;

    localparam int DEF_SAMPLE_W    = 10;
    localparam int DEF_BASELINE    = 0;
    localparam int DEF_TH_HI       = 200;
    localparam int DEF_TH_LO       = 120;
    localparam int DEF_MIN_SAMPLES = 3;
    localparam int DEF_HOLDOFF_CYC = 4096;
    localparam int DEF_DEB_CYC     = 1024;

    // Width of a counter that must hold values 0 .. n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shake_input_frontend_btn_debounce.sv
// Two-flop synchronizer plus stability counter; emits a one-cycle pulse on each debounced press.
module btn_debounce
    import shake_input_frontend_pkg::*;
#(
    parameter int DEB_CYC = DEF_DEB_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    localparam int unsigned CW = cnt_w(DEB_CYC);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            pulse_q <= 1'b0;
            if (sync2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYC - 1)) begin
                deb_q   <= sync2_q;
                cnt_q   <= '0;
                // Only the rising debounced level produces a pulse.
                pulse_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/shake_input_frontend.sv
// Accelerometer shake detector (threshold/hysteresis/holdoff) and debounced next/prev buttons.
module shake_input_frontend
    import shake_input_frontend_pkg::*;
#(
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int BASELINE    = DEF_BASELINE,
    parameter int TH_HI       = DEF_TH_HI,
    parameter int TH_LO       = DEF_TH_LO,
    parameter int MIN_SAMPLES = DEF_MIN_SAMPLES,
    parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
    parameter int DEB_CYC     = DEF_DEB_CYC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [SAMPLE_W-1:0] acc_sample,
    input  logic                       acc_valid,
    input  logic                       btn_next_raw,
    input  logic                       btn_prev_raw,
    output logic                       shake,
    output logic                       next,
    output logic                       prev
);

    localparam int unsigned HW = cnt_w(HOLDOFF_CYC);
    localparam logic signed [SAMPLE_W:0] BASE_EXT = (SAMPLE_W + 1)'(BASELINE);
    localparam logic [SAMPLE_W:0] TH_HI_M = (SAMPLE_W + 1)'(TH_HI);
    localparam logic [SAMPLE_W:0] TH_LO_M = (SAMPLE_W + 1)'(TH_LO);

    logic signed [SAMPLE_W:0] diff;
    logic [SAMPLE_W:0]        mag_d;
    logic [SAMPLE_W:0]        mag_q;
    logic                     mag_v_q;
    logic                     hi;
    logic                     settled;

    shake_state_t  state_q;
    logic [3:0]    cnt_q;
    logic [HW-1:0] hold_q;
    logic          shake_q;

    logic next_pulse;
    logic prev_pulse;
    logic next_q;
    logic prev_q;

    // One extra bit keeps the subtraction and the negation of the most negative sample exact.
    always_comb begin
        diff  = $signed({acc_sample[SAMPLE_W-1], acc_sample}) - BASE_EXT;
        mag_d = diff[SAMPLE_W] ? $unsigned(-diff) : $unsigned(diff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q   <= '0;
            mag_v_q <= 1'b0;
        end else begin
            mag_v_q <= acc_valid;
            if (acc_valid) begin
                mag_q <= mag_d;
            end
        end
    end

    assign hi      = (mag_q >= TH_HI_M);
    assign settled = (mag_q < TH_LO_M);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            shake_q <= 1'b0;
        end else begin
            shake_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (mag_v_q && hi) begin
                        if (MIN_SAMPLES == 1) begin
                            cnt_q   <= '0;
                            shake_q <= 1'b1;
                            state_q <= WAIT_LO;
                        end else begin
                            cnt_q   <= 4'd1;
                            state_q <= ARM;
                        end
                    end
                end
                ARM: begin
                    if (mag_v_q) begin
                        if (!hi) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else if (cnt_q + 4'd1 == 4'(MIN_SAMPLES)) begin
                            cnt_q   <= '0;
                            shake_q <= 1'b1;
                            state_q <= WAIT_LO;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                WAIT_LO: begin
                    if (mag_v_q && settled) begin
                        hold_q  <= HW'(HOLDOFF_CYC - 1);
                        state_q <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    // Counts every clk; sample validity is irrelevant here.
                    if (hold_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        hold_q <= hold_q - HW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    btn_debounce #(
        .DEB_CYC(DEB_CYC)
    ) u_deb_next (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_next_raw),
        .pulse(next_pulse)
    );

    btn_debounce #(
        .DEB_CYC(DEB_CYC)
    ) u_deb_prev (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_prev_raw),
        .pulse(prev_pulse)
    );

    // next wins when both pulses land together, matching downstream priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            next_q <= next_pulse;
            prev_q <= prev_pulse & ~next_pulse;
        end
    end

    assign shake = shake_q;
    assign next  = next_q;
    assign prev  = prev_q;

endmodule
